// File: rtl/dpram_pkg.sv
// Shared types for the arbitrated dual-port RAM.
//   rd_mode_e : read-during-write behaviour (old data or new data)
//   hold_t    : parked port-B write; sized for the widest legal configuration
package dpram_pkg;

  typedef enum logic {
    RD_FIRST = 1'b0,
    WR_FIRST = 1'b1
  } rd_mode_e;

  localparam int unsigned HOLD_ADDR_W = 32'd32;
  localparam int unsigned HOLD_DATA_W = 32'd64;

  typedef struct packed {
    logic [HOLD_ADDR_W-1:0] addr;
    logic [HOLD_DATA_W-1:0] data;
    logic                   vld;
  } hold_t;

  localparam hold_t HOLD_CLEAR = '{
    addr: {HOLD_ADDR_W{1'b0}},
    data: {HOLD_DATA_W{1'b0}},
    vld:  1'b0
  };

endpackage

// File: rtl/dpram_bank.sv
// Raw true-dual-port array, no arbitration.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset (read regs only)
//   en_a/we_a/addr_a/din_a, en_b/we_b/addr_b/din_b : two synchronous ports
//   dout_a, dout_b      : registered read data, held while the port is not reading
// A read on one port that hits the address written by the other port in the
// same cycle returns old data (RD_FIRST) or the incoming write data (WR_FIRST).
module dpram_bank
  import dpram_pkg::*;
#(
  parameter int unsigned DATA_W  = 32'd8,
  parameter int unsigned ADDR_W  = 32'd6,
  parameter rd_mode_e    RD_MODE = RD_FIRST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_a,
  output logic [DATA_W-1:0] dout_b
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_a_s;
  logic [DATA_W-1:0] rd_b_s;
  logic [DATA_W-1:0] dout_a_r;
  logic [DATA_W-1:0] dout_b_r;

  // Array write; A is applied last so it wins should both ever target one word.
  always_ff @(posedge clk) begin
    if (en_b && we_b) begin
      mem_r[addr_b] <= din_b;
    end
    if (en_a && we_a) begin
      mem_r[addr_a] <= din_a;
    end
  end

  // Port A read data with bypass of a same-address port-B write.
  always_comb begin
    rd_a_s = mem_r[addr_a];
    if ((RD_MODE == WR_FIRST) && en_b && we_b && (addr_b == addr_a)) begin
      rd_a_s = din_b;
    end else begin
      rd_a_s = mem_r[addr_a];
    end
  end

  // Port B read data with bypass of a same-address port-A write.
  always_comb begin
    rd_b_s = mem_r[addr_b];
    if ((RD_MODE == WR_FIRST) && en_a && we_a && (addr_a == addr_b)) begin
      rd_b_s = din_a;
    end else begin
      rd_b_s = mem_r[addr_b];
    end
  end

  // Read registers: load on a read, otherwise hold the last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_a_r <= {DATA_W{1'b0}};
      dout_b_r <= {DATA_W{1'b0}};
    end else begin
      if (en_a && !we_a) begin
        dout_a_r <= rd_a_s;
      end
      if (en_b && !we_b) begin
        dout_b_r <= rd_b_s;
      end
    end
  end

  assign dout_a = dout_a_r;
  assign dout_b = dout_b_r;

endmodule

// File: rtl/dual_port_ram_arb.sv
// Dual-port RAM with deterministic same-address write/write arbitration.
// Ports:
//   clk, rst                        : clock, asynchronous active-low reset
//   en_A/we_A/addr_A/din_A          : port A request
//   en_B/we_B/addr_B/din_B          : port B request (ignored while busy_B)
//   dout_A/dout_B, valid_A/valid_B  : registered read data and its valid pulse
//   busy_B                          : B's colliding write is being retired
//   coll_cnt                        : saturating write/write collision count
// On a collision A writes, B is parked in the hold register and committed on
// the next edge through the B path, unless A overwrites that word first.
module dual_port_ram_arb
  import dpram_pkg::*;
#(
  parameter int unsigned DATA_W  = 32'd8,
  parameter int unsigned ADDR_W  = 32'd6,
  parameter rd_mode_e    RD_MODE = RD_FIRST,
  parameter int unsigned COLL_W  = 32'd8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_A,
  input  logic              we_A,
  input  logic [ADDR_W-1:0] addr_A,
  input  logic [DATA_W-1:0] din_A,
  input  logic              en_B,
  input  logic              we_B,
  input  logic [ADDR_W-1:0] addr_B,
  input  logic [DATA_W-1:0] din_B,
  output logic [DATA_W-1:0] dout_A,
  output logic [DATA_W-1:0] dout_B,
  output logic              valid_A,
  output logic              valid_B,
  output logic              busy_B,
  output logic [COLL_W-1:0] coll_cnt
);

  hold_t             hold_r;
  logic [ADDR_W-1:0] hold_addr_s;
  logic [DATA_W-1:0] hold_data_s;
  logic              unused_hold_s;
  logic              a_wr_s;
  logic              coll_s;
  logic              hold_kill_s;
  logic              bank_en_b_s;
  logic              bank_we_b_s;
  logic [ADDR_W-1:0] bank_addr_b_s;
  logic [DATA_W-1:0] bank_din_b_s;
  logic              valid_a_r;
  logic              valid_b_r;
  logic [COLL_W-1:0] coll_cnt_r;

  assign hold_addr_s   = hold_r.addr[ADDR_W-1:0];
  assign hold_data_s   = hold_r.data[DATA_W-1:0];
  // Upper hold bits exist only to fit the widest configuration.
  assign unused_hold_s = ^(hold_r.addr >> ADDR_W) ^ ^(hold_r.data >> DATA_W);

  assign a_wr_s      = en_A && we_A;
  // No new collision can start while the previous one is retiring.
  assign coll_s      = a_wr_s && en_B && we_B && (addr_A == addr_B) && !hold_r.vld;
  // A writing the parked address in the retire cycle supersedes the hold.
  assign hold_kill_s = a_wr_s && (addr_A == hold_addr_s);

  // Port-B path into the bank: retiring hold or live B request.
  always_comb begin
    bank_en_b_s   = 1'b0;
    bank_we_b_s   = 1'b0;
    bank_addr_b_s = addr_B;
    bank_din_b_s  = din_B;
    if (hold_r.vld) begin
      bank_en_b_s   = !hold_kill_s;
      bank_we_b_s   = 1'b1;
      bank_addr_b_s = hold_addr_s;
      bank_din_b_s  = hold_data_s;
    end else begin
      bank_en_b_s   = en_B && !coll_s;
      bank_we_b_s   = we_B;
      bank_addr_b_s = addr_B;
      bank_din_b_s  = din_B;
    end
  end

  // Hold register: park B on a collision, clear after the one retire cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_r <= HOLD_CLEAR;
    end else if (coll_s) begin
      hold_r <= '{addr: HOLD_ADDR_W'(addr_B), data: HOLD_DATA_W'(din_B), vld: 1'b1};
    end else begin
      hold_r <= HOLD_CLEAR;
    end
  end

  // Read-valid pulses; B reads are dropped while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_a_r <= 1'b0;
      valid_b_r <= 1'b0;
    end else begin
      valid_a_r <= en_A && !we_A;
      valid_b_r <= en_B && !we_B && !hold_r.vld;
    end
  end

  // Saturating collision counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coll_cnt_r <= {COLL_W{1'b0}};
    end else if (coll_s && (coll_cnt_r != {COLL_W{1'b1}})) begin
      coll_cnt_r <= coll_cnt_r + COLL_W'(1);
    end
  end

  dpram_bank #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .RD_MODE (RD_MODE)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .en_a   (en_A),
    .we_a   (we_A),
    .addr_a (addr_A),
    .din_a  (din_A),
    .en_b   (bank_en_b_s),
    .we_b   (bank_we_b_s),
    .addr_b (bank_addr_b_s),
    .din_b  (bank_din_b_s),
    .dout_a (dout_A),
    .dout_b (dout_B)
  );

  assign valid_A  = valid_a_r;
  assign valid_B  = valid_b_r;
  assign busy_B   = hold_r.vld;
  assign coll_cnt = coll_cnt_r;

endmodule

// File: tb/tb_dual_port_ram_arb.sv
// Randomised and directed bench for dual_port_ram_arb. Two instances (old-data
// and new-data read-during-write) share one stimulus; a word-level model of
// the arbitration rules predicts every output after each clock edge.
module tb_dual_port_ram_arb;
  import dpram_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_A = 1'b0, we_A = 1'b0, en_B = 1'b0, we_B = 1'b0;
  logic [5:0] addr_A = 6'd0, addr_B = 6'd0;
  logic [7:0] din_A = 8'd0, din_B = 8'd0;

  logic [7:0] rf_dout_A, rf_dout_B, wf_dout_A, wf_dout_B, rf_cnt, wf_cnt;
  logic       rf_vA, rf_vB, rf_busy, wf_vA, wf_vB, wf_busy;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [7:0] m_mem [64];
  bit         m_busy = 1'b0;
  int         m_hold_addr = 0;
  logic [7:0] m_hold_data = 8'd0;
  int         m_cnt = 0;
  logic [7:0] e_dA_rf = 8'd0, e_dA_wf = 8'd0, e_dB_rf = 8'd0, e_dB_wf = 8'd0;
  bit         e_vA = 1'b0, e_vB = 1'b0;
  logic [7:0] saved;

  always #5 clk = ~clk;

  dual_port_ram_arb #(.DATA_W(8), .ADDR_W(6), .RD_MODE(RD_FIRST), .COLL_W(8)) u_rf (
    .clk(clk), .rst(rst),
    .en_A(en_A), .we_A(we_A), .addr_A(addr_A), .din_A(din_A),
    .en_B(en_B), .we_B(we_B), .addr_B(addr_B), .din_B(din_B),
    .dout_A(rf_dout_A), .dout_B(rf_dout_B), .valid_A(rf_vA), .valid_B(rf_vB),
    .busy_B(rf_busy), .coll_cnt(rf_cnt)
  );

  dual_port_ram_arb #(.DATA_W(8), .ADDR_W(6), .RD_MODE(WR_FIRST), .COLL_W(8)) u_wf (
    .clk(clk), .rst(rst),
    .en_A(en_A), .we_A(we_A), .addr_A(addr_A), .din_A(din_A),
    .en_B(en_B), .we_B(we_B), .addr_B(addr_B), .din_B(din_B),
    .dout_A(wf_dout_A), .dout_B(wf_dout_B), .valid_A(wf_vA), .valid_B(wf_vB),
    .busy_B(wf_busy), .coll_cnt(wf_cnt)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check_val("rf_dout_A", 64'(rf_dout_A), 64'(e_dA_rf));
    check_val("wf_dout_A", 64'(wf_dout_A), 64'(e_dA_wf));
    check_val("rf_dout_B", 64'(rf_dout_B), 64'(e_dB_rf));
    check_val("wf_dout_B", 64'(wf_dout_B), 64'(e_dB_wf));
    check_val("rf_valid_A", 64'(rf_vA), 64'(e_vA));
    check_val("wf_valid_A", 64'(wf_vA), 64'(e_vA));
    check_val("rf_valid_B", 64'(rf_vB), 64'(e_vB));
    check_val("wf_valid_B", 64'(wf_vB), 64'(e_vB));
    check_val("rf_busy_B", 64'(rf_busy), 64'(m_busy));
    check_val("wf_busy_B", 64'(wf_busy), 64'(m_busy));
    check_val("rf_coll_cnt", 64'(rf_cnt), 64'(m_cnt));
    check_val("wf_coll_cnt", 64'(wf_cnt), 64'(m_cnt));
  endtask

  // Drive one request pair, advance the model by one edge, check after the edge.
  task automatic cycle(input bit ea, input bit wa, input int aa, input logic [7:0] da,
                       input bit eb, input bit wb, input int ab, input logic [7:0] db);
    bit a_wr, a_rd, b_wr, b_rd, hold_commit, coll;
    en_A = ea; we_A = wa; addr_A = 6'(aa); din_A = da;
    en_B = eb; we_B = wb; addr_B = 6'(ab); din_B = db;
    a_wr = ea && wa;
    a_rd = ea && !wa;
    b_wr = eb && wb && !m_busy;
    b_rd = eb && !wb && !m_busy;
    hold_commit = m_busy && !(a_wr && (aa == m_hold_addr));
    coll = a_wr && b_wr && (aa == ab);
    if (a_rd) begin
      e_dA_rf = m_mem[aa];
      e_dA_wf = m_mem[aa];
      if (hold_commit && (m_hold_addr == aa)) e_dA_wf = m_hold_data;
      if (b_wr && (ab == aa)) e_dA_wf = db;
    end
    if (b_rd) begin
      e_dB_rf = m_mem[ab];
      e_dB_wf = (a_wr && (aa == ab)) ? da : m_mem[ab];
    end
    e_vA = a_rd;
    e_vB = b_rd;
    // older writes first: parked B, then this cycle's B, then this cycle's A
    if (hold_commit) m_mem[m_hold_addr] = m_hold_data;
    if (b_wr && !coll) m_mem[ab] = db;
    if (a_wr) m_mem[aa] = da;
    m_busy = coll;
    if (coll) begin
      m_hold_addr = ab;
      m_hold_data = db;
      if (m_cnt < 255) m_cnt++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 0, 8'd0, 1'b0, 1'b0, 0, 8'd0);
  endtask

  initial begin
    // reset
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // fill the whole array so every later read has a known value
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 1'b1, i, 8'($urandom), 1'b0, 1'b0, 0, 8'd0);
    end

    // write A then read B
    cycle(1'b1, 1'b1, 5, 8'h3C, 1'b0, 1'b0, 0, 8'd0);
    cycle(1'b0, 1'b0, 0, 8'd0, 1'b1, 1'b0, 5, 8'd0);
    check_val("rd_after_wr_dout", 64'(rf_dout_B), 64'h3C);
    check_val("rd_after_wr_valid", 64'(rf_vB), 64'h1);

    // plain collision: B retired after A
    cycle(1'b1, 1'b1, 9, 8'h11, 1'b1, 1'b1, 9, 8'h22);
    check_val("coll_busy_hi", 64'(rf_busy), 64'h1);
    check_val("coll_cnt_1", 64'(rf_cnt), 64'h1);
    idle();
    check_val("coll_busy_lo", 64'(rf_busy), 64'h0);
    cycle(1'b1, 1'b0, 9, 8'd0, 1'b0, 1'b0, 0, 8'd0);
    check_val("coll_b_wins", 64'(rf_dout_A), 64'h22);

    // A overwrites the parked address during retire
    cycle(1'b1, 1'b1, 9, 8'h11, 1'b1, 1'b1, 9, 8'h22);
    cycle(1'b1, 1'b1, 9, 8'h33, 1'b0, 1'b0, 0, 8'd0);
    cycle(1'b0, 1'b0, 0, 8'd0, 1'b1, 1'b0, 9, 8'd0);
    check_val("retire_a_wins", 64'(rf_dout_B), 64'h33);

    // read-during-write mode
    cycle(1'b1, 1'b1, 4, 8'hAA, 1'b0, 1'b0, 0, 8'd0);
    cycle(1'b1, 1'b1, 4, 8'h55, 1'b1, 1'b0, 4, 8'd0);
    check_val("rdw_rd_first", 64'(rf_dout_B), 64'hAA);
    check_val("rdw_wr_first", 64'(wf_dout_B), 64'h55);

    // A read against the retiring hold
    cycle(1'b1, 1'b1, 12, 8'h01, 1'b1, 1'b1, 12, 8'h02);
    cycle(1'b1, 1'b0, 12, 8'd0, 1'b0, 1'b0, 0, 8'd0);
    check_val("hold_rd_first", 64'(rf_dout_A), 64'h01);
    check_val("hold_wr_first", 64'(wf_dout_A), 64'h02);

    // B read while busy is dropped
    cycle(1'b1, 1'b1, 7, 8'h01, 1'b1, 1'b1, 7, 8'h02);
    saved = rf_dout_B;
    cycle(1'b0, 1'b0, 0, 8'd0, 1'b1, 1'b0, 5, 8'd0);
    check_val("busy_rd_valid", 64'(rf_vB), 64'h0);
    check_val("busy_rd_hold", 64'(rf_dout_B), 64'(saved));

    // random traffic on a few addresses so collisions are frequent
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 8'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 8'($urandom));
    end
    idle();

    // counter saturation
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 1'b1, 20, 8'($urandom), 1'b1, 1'b1, 20, 8'($urandom));
      idle();
    end
    check_val("coll_cnt_sat", 64'(rf_cnt), 64'hFF);

    // reset during retire drops the parked write
    cycle(1'b1, 1'b1, 9, 8'h11, 1'b1, 1'b1, 9, 8'h22);
    en_A = 1'b0; we_A = 1'b0; en_B = 1'b0; we_B = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    m_busy = 1'b0;
    m_cnt = 0;
    e_dA_rf = 8'd0; e_dA_wf = 8'd0; e_dB_rf = 8'd0; e_dB_wf = 8'd0;
    e_vA = 1'b0; e_vB = 1'b0;
    check_val("rst_busy_drop", 64'(rf_busy), 64'h0);
    check_all();
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 1'b0, 0, 8'd0, 1'b1, 1'b0, 9, 8'd0);
    check_val("rst_keeps_a", 64'(rf_dout_B), 64'h11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_arb.md
# dual_port_ram_arb

Parametrised successor to the team's dual-port RAM: two independent read/write ports (A, B) on one clock, with configurable data width, depth and read-during-write mode. Same-address write/write collisions are resolved deterministically: port A commits first, port B's write is held for one cycle and then retired, and port B signals `busy_B` for that cycle. A saturating collision counter is exposed for coverage and debug. The block is the storage element under test in the RAM verification environment and replaces the fixed-size DUT.

## Interface
- `DATA_W`, 8, data width in bits (1..64)
- `ADDR_W`, 6, address width; depth = 2**ADDR_W
- `RD_MODE`, `RD_FIRST`, read-during-write behaviour (`RD_FIRST` = old data, `WR_FIRST` = new data), type `dpram_pkg::rd_mode_e`
- `COLL_W`, 8, width of collision counter

- `clk` in 1 — single clock, all logic on rising edge
- `rst` in 1 — asynchronous, active-low reset
- `en_A` / `en_B` in 1 — port request valid
- `we_A` / `we_B` in 1 — write (1) or read (0), qualified by `en_X`
- `addr_A` / `addr_B` in ADDR_W — address
- `din_A` / `din_B` in DATA_W — write data
- `dout_A` / `dout_B` out DATA_W — registered read data
- `valid_A` / `valid_B` out 1 — `dout_X` valid this cycle
- `busy_B` out 1 — port B held; B request this cycle ignored
- `coll_cnt` out COLL_W — saturating count of write/write collisions

## Operation
- Reset (async, `rst`=0): `dout_A`/`dout_B`=0, `valid_A`/`valid_B`=0, `busy_B`=0, `coll_cnt`=0, hold register cleared. Array contents are not reset.
- Read: `en_X && !we_X` → `dout_X` and `valid_X`=1 on the next edge. `dout_X` holds its last value when `valid_X`=0.
- Write: `en_X && we_X` → array updated at the edge. No `valid_X` pulse.
- Write/write collision (both enabled, both write, `addr_A == addr_B`, `busy_B`=0):
  - A's data is written.
  - B's address and data are captured into the hold register.
  - `busy_B`=1 on the next cycle.
  - `coll_cnt` increments, saturating at all-ones.
- Retire cycle (`busy_B`=1):
  - Port B inputs are ignored; `valid_B`=0 next cycle.
  - The hold write commits through the B write path.
  - If A writes the hold address in the same cycle, A's data wins and the hold is discarded. Ordering is A(t) < B(t) < A(t+1).
- `busy_B` is always exactly one cycle. A new collision cannot occur during retire.
- Read/write on the same address (either direction, including an A read against the retiring hold): `RD_FIRST` returns the pre-write data; `WR_FIRST` returns the written data.
- Different addresses never interact.

## Timing
- Read latency 1 cycle; write visible to a read issued the following cycle.
- Collision at edge t → `busy_B` high during cycle t+1 → hold committed at edge t+1 → `busy_B` low at t+2.
- Reset asserted during retire: hold dropped and the write is lost; `busy_B` deasserts immediately (async).
- Reset deassertion must be synchronised externally. First accepted request is on the first edge with `rst`=1.

## Structure
- `dpram_pkg`: `rd_mode_e` enum {`RD_FIRST`, `WR_FIRST`}, plus a `hold_t` struct {`addr`, `data`, `vld`}.
- Sub-module `dpram_bank`: the raw true-dual-port array with two synchronous ports and `RD_MODE` handling, with no arbitration.
- Top level: collision detect, hold register, `busy_B`, the counter, and valid generation.
- Expected size 150–250 lines.

## Test plan
- Reset, then write A addr 5 = 0x3C, then read B addr 5 → `dout_B`=0x3C, `valid_B`=1 one cycle after the read.
- Same-cycle A write addr 9 = 0x11 and B write addr 9 = 0x22:
  - `busy_B`=1 for exactly one cycle; `coll_cnt`=1.
  - A later read of addr 9 returns 0x22.
- Collision on addr 9 (A=0x11, B=0x22), then A writes addr 9 = 0x33 in the retire cycle → read returns 0x33.
- `RD_FIRST` with addr 4 pre-loaded 0xAA; A writes 0x55 while B reads addr 4 → `dout_B`=0xAA. Under `WR_FIRST` → 0x55.
- B read issued while `busy_B`=1 → `valid_B` stays 0; `dout_B` unchanged.
- 300 collisions with `COLL_W`=8 → `coll_cnt` saturates at 255.
- Assert `rst` during the retire cycle of a collision (B=0x22 on addr 9) → `busy_B` drops immediately; addr 9 keeps A's data.
